// File: rtl/dt_pkg.sv
// Shared types and helpers for the decision-tree feature loader slice.
package dt_pkg;

  localparam int unsigned DT_N = 8;
  localparam int unsigned DT_C = 1;

  typedef enum logic [1:0] {
    StFill,
    StDrain,
    StEval,
    StResult
  } dt_state_e;

  // Index width for a frame of num_feat beats; never narrower than one bit.
  function automatic int unsigned feat_idx_w(input int unsigned num_feat);
    return (num_feat > 1) ? $clog2(num_feat) : 1;
  endfunction

endpackage

// File: rtl/dt_feature_bank.sv
// NUM_FEAT x N feature register bank with indexed write and flat output.
module dt_feature_bank
  import dt_pkg::*;
#(
  parameter int unsigned N        = DT_N,
  parameter int unsigned NUM_FEAT = 30,
  parameter int unsigned IW       = feat_idx_w(NUM_FEAT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [N-1:0]          wdata,
  output logic [NUM_FEAT*N-1:0] feat_flat
);

  logic [NUM_FEAT*N-1:0] bank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
    end else if (we) begin
      for (int k = 0; k < NUM_FEAT; k++) begin
        if (widx == IW'(k)) begin
          bank_q[k*N +: N] <= wdata;
        end
      end
    end
  end

  assign feat_flat = bank_q;

endmodule

// File: rtl/dt_feature_loader.sv
// Serial-to-parallel feature loader feeding a combinational decision tree.
// Optional DT_FRAME_CNT_EN adds frame_cnt / err_cnt result counters.
module dt_feature_loader
  import dt_pkg::*;
#(
  parameter int unsigned N        = DT_N,
  parameter int unsigned NUM_FEAT = 30,
  parameter int unsigned C        = DT_C
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [N-1:0]          s_data,
  input  logic                  s_last,
  output logic [NUM_FEAT*N-1:0] feat_flat,
  output logic                  feat_valid,
  input  logic [C-1:0]          cls_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [C-1:0]          m_cls,
  output logic                  m_err
`ifdef DT_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [7:0]            err_cnt
`endif
);

  localparam int unsigned IW = feat_idx_w(NUM_FEAT);
  localparam logic [IW-1:0] LastIdx = IW'(NUM_FEAT - 1);

  dt_state_e     state_q;
  logic [IW-1:0] idx_q;
  logic          err_q;
  logic          s_ready_q;
  logic          feat_valid_q;
  logic          m_valid_q;
  logic [C-1:0]  m_cls_q;
  logic          m_err_q;

  logic beat;
  logic bank_we;
  logic handshake;

  always_comb begin
    beat      = s_valid & s_ready_q;
    bank_we   = beat & (state_q == StFill);
    handshake = m_valid_q & m_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      idx_q        <= '0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b1;
      feat_valid_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_cls_q      <= '0;
      m_err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (beat) begin
            if (s_last) begin
              // Early last leaves unwritten features at previous-frame values.
              if (idx_q != LastIdx) err_q <= 1'b1;
              idx_q        <= '0;
              s_ready_q    <= 1'b0;
              feat_valid_q <= 1'b1;
              state_q      <= StEval;
            end else if (idx_q == LastIdx) begin
              err_q   <= 1'b1;
              idx_q   <= '0;
              state_q <= StDrain;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (beat && s_last) begin
            s_ready_q    <= 1'b0;
            feat_valid_q <= 1'b1;
            state_q      <= StEval;
          end
        end
        StEval: begin
          // Bank has been stable for this whole cycle, so cls_in has settled.
          m_cls_q   <= cls_in;
          m_err_q   <= err_q;
          m_valid_q <= 1'b1;
          state_q   <= StResult;
        end
        StResult: begin
          if (handshake) begin
            m_valid_q    <= 1'b0;
            err_q        <= 1'b0;
            feat_valid_q <= 1'b0;
            s_ready_q    <= 1'b1;
            state_q      <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  dt_feature_bank #(
    .N        (N),
    .NUM_FEAT (NUM_FEAT),
    .IW       (IW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (bank_we),
    .widx      (idx_q),
    .wdata     (s_data),
    .feat_flat (feat_flat)
  );

  assign s_ready    = s_ready_q;
  assign feat_valid = feat_valid_q;
  assign m_valid    = m_valid_q;
  assign m_cls      = m_cls_q;
  assign m_err      = m_err_q;

`ifdef DT_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (handshake) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
      if (m_err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_dt_feature_loader.sv
// Randomised self-checking bench for dt_feature_loader against a frame-level model.
module tb_dt_feature_loader;

  localparam int N        = 8;
  localparam int NUM_FEAT = 30;
  localparam int C        = 1;
  localparam int W        = N * NUM_FEAT;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         s_last;
  logic [W-1:0] feat_flat;
  logic         feat_valid;
  logic [C-1:0] cls_in;
  logic         m_valid;
  logic         m_ready;
  logic [C-1:0] m_cls;
  logic         m_err;
`ifdef DT_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
  logic [7:0]   err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [N-1:0] beat_data [64];
  logic [N-1:0] mbank [NUM_FEAT];
  logic         exp_err;
  int           m_frames;
  int           m_errs;
  bit           gaps;

  always #5 clk = ~clk;

  dt_feature_loader #(
    .N        (N),
    .NUM_FEAT (NUM_FEAT),
    .C        (C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .feat_flat  (feat_flat),
    .feat_valid (feat_valid),
    .cls_in     (cls_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_cls      (m_cls),
    .m_err      (m_err)
`ifdef DT_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_flat();
    logic [W-1:0] f = '0;
    for (int k = 0; k < NUM_FEAT; k++) f[k*N +: N] = mbank[k];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NUM_FEAT; k++) mbank[k] = '0;
    m_frames = 0;
    m_errs   = 0;
  endtask

  // Streams beat_data[0..nbeats-1]; s_last on beat last_at. Updates the model bank.
  task automatic send_frame(input int nbeats, input int last_at);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < nbeats && guard < 400) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = beat_data[i];
      s_last  = (i == last_at);
      acc     = s_valid && s_ready;
      tick();
      guard++;
      if (acc) i++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (i < nbeats) check("send_timeout", W'(i), W'(nbeats));
    for (int k = 0; k < NUM_FEAT && k <= last_at && k < nbeats; k++) mbank[k] = beat_data[k];
    exp_err = (last_at != NUM_FEAT - 1);
  endtask

  // Called in the cycle right after the last beat was accepted.
  task automatic finish_frame(input logic [C-1:0] exp_cls, input int stall);
    logic [W-1:0] bank_snap;
    check("feat_valid_eval", W'(feat_valid), W'(1'b1));
    check("m_valid_eval", W'(m_valid), W'(1'b0));
    check("s_ready_eval", W'(s_ready), W'(1'b0));
    tick();
    bank_snap = model_flat();
    check("m_valid", W'(m_valid), W'(1'b1));
    check("m_cls", W'(m_cls), W'(exp_cls));
    check("m_err", W'(m_err), W'(exp_err));
    check("bank", feat_flat, bank_snap);
    for (int j = 0; j < stall; j++) begin
      cls_in  = ~cls_in;
      s_valid = 1'b1;
      s_data  = 8'hFF;
      s_last  = 1'b1;
      tick();
      check("stall_m_cls", W'(m_cls), W'(exp_cls));
      check("stall_s_ready", W'(s_ready), W'(1'b0));
      check("stall_m_valid", W'(m_valid), W'(1'b1));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (stall > 0) check("stall_bank", feat_flat, bank_snap);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    m_frames++;
    if (exp_err) m_errs++;
    check("post_m_valid", W'(m_valid), W'(1'b0));
    check("post_feat_valid", W'(feat_valid), W'(1'b0));
    check("post_s_ready", W'(s_ready), W'(1'b1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, nb, la, stall;
    logic [C-1:0] c;
    s_data = '0;
    cls_in = '0;
    gaps   = 1'b0;
    do_reset();

    check("rst_s_ready", W'(s_ready), W'(1'b1));
    check("rst_feat_valid", W'(feat_valid), W'(1'b0));
    check("rst_m_valid", W'(m_valid), W'(1'b0));
    check("rst_m_cls", W'(m_cls), W'(1'b0));
    check("rst_m_err", W'(m_err), W'(1'b0));
    check("rst_bank", feat_flat, W'(0));

    // Nominal frame, beat k carries k+1.
    for (int k = 0; k < NUM_FEAT; k++) beat_data[k] = N'(k + 1);
    cls_in = 1'b1;
    send_frame(30, 29);
    check("nom_feat0", W'(feat_flat[7:0]), W'(8'd1));
    check("nom_feat29", W'(feat_flat[239:232]), W'(8'd30));
    finish_frame(1'b1, 0);

    // Early last after a frame of 0x11.
    for (int k = 0; k < NUM_FEAT; k++) beat_data[k] = 8'h11;
    cls_in = 1'b0;
    send_frame(30, 29);
    finish_frame(1'b0, 0);
    for (int k = 0; k < NUM_FEAT; k++) beat_data[k] = 8'hAA;
    send_frame(10, 9);
    check("early_feat9", W'(feat_flat[9*N +: N]), W'(8'hAA));
    check("early_feat10", W'(feat_flat[10*N +: N]), W'(8'h11));
    check("early_err", W'(exp_err), W'(1'b1));
    finish_frame(1'b0, 0);

    // Missing last: 35 beats, last on beat 34.
    for (int k = 0; k < 35; k++) beat_data[k] = N'($urandom);
    cls_in = 1'b1;
    send_frame(35, 34);
    finish_frame(1'b1, 0);
    tick();
    tick();
    check("single_result", W'(m_valid), W'(1'b0));

    // Backpressure for 20 cycles with cls_in toggling.
    for (int k = 0; k < NUM_FEAT; k++) beat_data[k] = N'($urandom);
    cls_in = 1'b1;
    send_frame(30, 29);
    finish_frame(1'b1, 20);

    // Reset mid-frame.
    for (int k = 0; k < NUM_FEAT; k++) beat_data[k] = N'($urandom);
    send_frame(16, 99);
    do_reset();
    check("midrst_bank", feat_flat, W'(0));
    check("midrst_m_valid", W'(m_valid), W'(1'b0));
    check("midrst_s_ready", W'(s_ready), W'(1'b1));
    for (int k = 0; k < NUM_FEAT; k++) beat_data[k] = N'($urandom);
    cls_in = 1'b0;
    send_frame(30, 29);
    finish_frame(1'b0, 0);

    // Reset while a result is pending.
    send_frame(30, 29);
    tick();
    check("res_m_valid", W'(m_valid), W'(1'b1));
    do_reset();
    check("resrst_m_valid", W'(m_valid), W'(1'b0));
    check("resrst_feat_valid", W'(feat_valid), W'(1'b0));
    check("resrst_bank", feat_flat, W'(0));

    // Randomised frames with gaps, mixed frame shapes and random stalls.
    gaps = 1'b1;
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        nb = NUM_FEAT;
        la = NUM_FEAT - 1;
      end else if (kind < 8) begin
        la = $urandom_range(0, NUM_FEAT - 2);
        nb = la + 1;
      end else begin
        nb = $urandom_range(NUM_FEAT + 1, 40);
        la = nb - 1;
      end
      for (int k = 0; k < nb; k++) beat_data[k] = N'($urandom);
      c      = C'($urandom_range(0, 1));
      cls_in = c;
      stall  = $urandom_range(0, 3);
      send_frame(nb, la);
      finish_frame(c, stall);
    end
    gaps = 1'b0;

`ifdef DT_FRAME_CNT_EN
    check("cnt_frames_rand", W'(frame_cnt), W'(m_frames));
    check("cnt_errs_rand", W'(err_cnt), W'(m_errs));
    do_reset();
    check("cnt_rst", W'(frame_cnt), W'(0));
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NUM_FEAT; k++) beat_data[k] = N'($urandom);
      cls_in = 1'b1;
      if (f < 3) send_frame(30, 29);
      else send_frame(5, 4);
      finish_frame(1'b1, 0);
    end
    check("cnt_frames", W'(frame_cnt), W'(16'd4));
    check("cnt_errs", W'(err_cnt), W'(8'd1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
